// File: rtl/fpa_pkg.sv
// Shared types, constants and helpers for the pipelined binary32 adder.
package fpa_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 24;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic nan;
        logic inf;
        logic inf_sign;
        logic neg_zero;
    } flags_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MAN_W:0]    man;
        flags_t            flags;
    } stage_t;

    // Leading-zero count of a 24-bit mantissa; 24 when the value is zero.
    function automatic logic [4:0] lzc24(input logic [MAN_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(MAN_W - 1 - i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return n;
    endfunction

    // Special-operand classification, evaluated once on the raw operands.
    function automatic flags_t special_flags(input logic [31:0] x, input logic [31:0] y);
        flags_t f;
        logic   x_exp_max;
        logic   y_exp_max;
        logic   x_inf;
        logic   y_inf;
        x_exp_max  = (x[30:23] == EXP_MAX);
        y_exp_max  = (y[30:23] == EXP_MAX);
        x_inf      = x_exp_max && (x[22:0] == 23'h0);
        y_inf      = y_exp_max && (y[22:0] == 23'h0);
        f.nan      = (x_exp_max && (x[22:0] != 23'h0)) ||
                     (y_exp_max && (y[22:0] != 23'h0)) ||
                     (x_inf && y_inf && (x[31] != y[31]));
        f.inf      = x_inf || y_inf;
        f.inf_sign = x_inf ? x[31] : y[31];
        f.neg_zero = (x == 32'h8000_0000) && (y == 32'h8000_0000);
        return f;
    endfunction

endpackage

// File: rtl/fpa_pipelined_bs_right.sv
// Combinational logarithmic right barrel shifter; amounts of 32 or more give zero.
module bs_right (
    input  logic [31:0] data,
    input  logic [7:0]  amt,
    output logic [31:0] result
);

    logic [31:0] lvl1_s;
    logic [31:0] lvl2_s;
    logic [31:0] lvl3_s;
    logic [31:0] lvl4_s;
    logic [31:0] lvl5_s;

    assign lvl1_s = amt[0] ? {1'b0,  data[31:1]}    : data;
    assign lvl2_s = amt[1] ? {2'b00, lvl1_s[31:2]}  : lvl1_s;
    assign lvl3_s = amt[2] ? {4'h0,  lvl2_s[31:4]}  : lvl2_s;
    assign lvl4_s = amt[3] ? {8'h00, lvl3_s[31:8]}  : lvl3_s;
    assign lvl5_s = amt[4] ? {16'h0000, lvl4_s[31:16]} : lvl4_s;
    assign result = (amt[7:5] != 3'b000) ? 32'h0000_0000 : lvl5_s;

endmodule

// File: rtl/fpa_pipelined.sv
// Six-stage binary32 adder, truncating rounding, one operand pair per clock.
module fpa_pipelined
    import fpa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    logic [31:0]      a_r;
    logic [31:0]      b_r;
    stage_t           s2_s;
    stage_t           s2_r;
    logic             s2_sign_b_s;
    logic             s2_sign_b_r;
    logic [MAN_W-1:0] s2_man_b_s;
    logic [MAN_W-1:0] s2_man_b_r;
    logic [EXP_W-1:0] s2_diff_s;
    logic [EXP_W-1:0] s2_diff_r;
    logic [31:0]      big_s;
    logic [31:0]      small_s;
    logic [EXP_W-1:0] exp_big_s;
    logic [EXP_W-1:0] exp_small_s;

    logic [31:0]      shifted_s;
    stage_t           s3_r;
    logic             s3_sign_b_r;
    logic [MAN_W-1:0] s3_man_b_r;

    stage_t           s4_s;
    stage_t           s4_r;

    logic [4:0]       lz_s;
    logic [EXP_W-1:0] lim_s;
    logic [4:0]       sh_s;
    logic [MAN_W-1:0] man_n_s;
    logic [EXP_W:0]   exp_n_s;
    logic [31:0]      arith_s;
    logic [31:0]      res5_s;
    logic [31:0]      res5_r;

    // Unpack, order by magnitude so the A path is never smaller, compute alignment distance.
    always_comb begin
        if (a_r[30:0] >= b_r[30:0]) begin
            big_s   = a_r;
            small_s = b_r;
        end else begin
            big_s   = b_r;
            small_s = a_r;
        end
        exp_big_s   = (big_s[30:23]   == 8'h00) ? 8'h01 : big_s[30:23];
        exp_small_s = (small_s[30:23] == 8'h00) ? 8'h01 : small_s[30:23];
        s2_s.sign   = big_s[31];
        s2_s.exp    = exp_big_s;
        s2_s.man    = {1'b0, (big_s[30:23] != 8'h00), big_s[22:0]};
        s2_s.flags  = special_flags(a_r, b_r);
        s2_sign_b_s = small_s[31];
        s2_man_b_s  = {(small_s[30:23] != 8'h00), small_s[22:0]};
        s2_diff_s   = exp_big_s - exp_small_s;
    end

    bs_right u_align (
        .data   ({8'h00, s2_man_b_r}),
        .amt    (s2_diff_r),
        .result (shifted_s)
    );

    // Magnitude add or subtract; the A path is the larger so the difference stays non-negative.
    always_comb begin
        s4_s = s3_r;
        if (s3_r.sign == s3_sign_b_r) begin
            s4_s.man = s3_r.man + {1'b0, s3_man_b_r};
        end else begin
            s4_s.man = s3_r.man - {1'b0, s3_man_b_r};
        end
    end

    // Normalize (left shift clamped at exponent 1), pack, then let specials override.
    always_comb begin
        lz_s  = lzc24(s4_r.man[MAN_W-1:0]);
        lim_s = s4_r.exp - 8'd1;
        if (s4_r.man[MAN_W]) begin
            sh_s    = 5'd0;
            man_n_s = s4_r.man[MAN_W:1];
            exp_n_s = {1'b0, s4_r.exp} + 9'd1;
        end else begin
            sh_s    = ({3'b000, lz_s} > lim_s) ? lim_s[4:0] : lz_s;
            man_n_s = s4_r.man[MAN_W-1:0] << sh_s;
            exp_n_s = {1'b0, s4_r.exp} - {4'h0, sh_s};
        end

        if (s4_r.man == 25'h0) begin
            arith_s = 32'h0000_0000;
        end else if (exp_n_s >= 9'h0FF) begin
            arith_s = {s4_r.sign, EXP_MAX, 23'h0};
        end else begin
            arith_s = {s4_r.sign, (man_n_s[MAN_W-1] ? exp_n_s[7:0] : 8'h00), man_n_s[FRAC_W-1:0]};
        end

        if (s4_r.flags.nan) begin
            res5_s = QNAN;
        end else if (s4_r.flags.inf) begin
            res5_s = {s4_r.flags.inf_sign, EXP_MAX, 23'h0};
        end else if (s4_r.flags.neg_zero) begin
            res5_s = 32'h8000_0000;
        end else begin
            res5_s = arith_s;
        end
    end

    // All six pipeline stages; reset clears every stage so in-flight pairs are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= 32'h0;
            b_r         <= 32'h0;
            s2_r        <= '0;
            s2_sign_b_r <= 1'b0;
            s2_man_b_r  <= '0;
            s2_diff_r   <= '0;
            s3_r        <= '0;
            s3_sign_b_r <= 1'b0;
            s3_man_b_r  <= '0;
            s4_r        <= '0;
            res5_r      <= 32'h0;
            c           <= 32'h0;
        end else begin
            a_r         <= a;
            b_r         <= b;
            s2_r        <= s2_s;
            s2_sign_b_r <= s2_sign_b_s;
            s2_man_b_r  <= s2_man_b_s;
            s2_diff_r   <= s2_diff_s;
            s3_r        <= s2_r;
            s3_sign_b_r <= s2_sign_b_r;
            s3_man_b_r  <= shifted_s[MAN_W-1:0];
            s4_r        <= s4_s;
            res5_r      <= res5_s;
            c           <= res5_r;
        end
    end

endmodule

// File: tb/tb_fpa_pipelined.sv
// Scoreboard bench for fpa_pipelined: expected sums are queued with their due cycle.
module tb_fpa_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] c_out;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          next_id = 0;
    int          due_q[$];
    logic [31:0] exp_q[$];
    int          id_q[$];

    fpa_pipelined dut (
        .clk (clk),
        .rst (rst),
        .a   (a_in),
        .b   (b_in),
        .c   (c_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            n_checks++;
            if (due_q[0] != cyc) begin
                n_fail++;
                $display("FAIL chk%0d: not compared on due cycle %0d (now %0d)", id_q[0], due_q[0], cyc);
            end else if (c_out !== exp_q[0]) begin
                n_fail++;
                $display("FAIL chk%0d: cycle %0d c=%08h expected %08h", id_q[0], cyc, c_out, exp_q[0]);
            end
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int due, input logic [31:0] e);
        due_q.push_back(due);
        exp_q.push_back(e);
        id_q.push_back(next_id);
        next_id++;
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        a_in = x;
        b_in = y;
        expect_at(cyc + 6, e);
        tick();
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y);
        a_in = x;
        b_in = y;
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        a_in = 32'h0;
        b_in = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_at(cyc, 32'h0);
            tick();
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) expect_at(cyc + i, 32'h0);

        issue(32'h4000_0000, 32'h4120_0000, 32'h4140_0000);
        issue(32'h4415_C000, 32'h4120_0000, 32'h4418_4000);
        issue(32'h447A_0000, 32'h47C3_4F80, 32'h47C5_4380);
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        issue(32'h4120_0000, 32'hC000_0000, 32'h4100_0000);
        issue(32'hC000_0000, 32'h4120_0000, 32'h4100_0000);
        issue(32'h4000_0000, 32'hC000_0000, 32'h0000_0000);
        issue(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        issue(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
        issue(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        issue(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        issue(32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
        issue(32'h0040_0000, 32'h0040_0000, 32'h0080_0000);
        issue(32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000);

        a_in = 32'h0;
        b_in = 32'h0;
        repeat (8) tick();

        // Mid-stream reset: the first three pairs must never reach c.
        drive(32'h4000_0000, 32'h4120_0000);
        drive(32'h4000_0000, 32'h4000_0000);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) expect_at(cyc + i, 32'h0);
        drive(32'h4120_0000, 32'hC000_0000);
        rst = 1'b0;
        issue(32'h4415_C000, 32'h4120_0000, 32'h4418_4000);
        issue(32'hC000_0000, 32'h4120_0000, 32'h4100_0000);
        issue(32'h0000_0001, 32'h0000_0001, 32'h0000_0002);

        a_in = 32'h0;
        b_in = 32'h0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
